auto_player: RTL and testbench

Automated opponent for the tic-tac-toe game controller: drives the controller's move-request interface (`playerWrite`/`playerInput`) from the board state (`gBoard`) instead of a human. When told it is its turn, it snapshots the board, scans the eight win lines for a winning move, then a blocking move, then falls back to a fixed preference order. It issues one write pulse and waits for the board to show its mark, re-scanning on timeout. Sits beside the game controller at top level and reads the same board bus the controller's memory array drives.

---
 rtl/ttt_pkg.sv | 39 +++
 rtl/auto_player_if.sv | 21 ++
 rtl/line_eval.sv | 26 ++
 rtl/auto_player.sv | 158 +++++++++++++++
 tb/tb_auto_player.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell encodings, win-line table, player FSM states.
package ttt_pkg;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1    = 2'b11;
  localparam logic [1:0] P2    = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_DRAW = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_P1   = 2'b11;

  typedef logic [3:0] cell_t;

  localparam cell_t LINE_TBL [8][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };

  // Fallback preference: centre, corners, then edges.
  localparam cell_t PICK_ORDER [9] = '{
    4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
  };

  typedef enum logic [2:0] {
    StIdle, StScanWin, StScanBlock, StPick, StIssue, StWaitAck
  } state_e;

  function automatic logic [1:0] cell_at(input logic [17:0] b, input cell_t i);
    logic [1:0] r;
    r = EMPTY;
    for (int k = 0; k < 9; k++) begin
      if (i == cell_t'(k)) r = b[2*k +: 2];
    end
    return r;
  endfunction

endpackage

// File: rtl/auto_player_if.sv
// Move-request and board bus between the game controller and an automated player.
interface auto_player_if;
  logic [17:0] gBoard;
  logic        myTurn;
  logic        isPlayer1;
  logic        gameIsDone;
  logic        playerWrite;
  logic [3:0]  playerInput;
  logic        busy;
  logic        noMove;

  modport master (
    input  gBoard, myTurn, isPlayer1, gameIsDone,
    output playerWrite, playerInput, busy, noMove
  );

  modport slave (
    output gBoard, myTurn, isPlayer1, gameIsDone,
    input  playerWrite, playerInput, busy, noMove
  );
endinterface

// File: rtl/line_eval.sv
// Combinational check of one win line: two cells hold mark and the third is empty.
module line_eval
  import ttt_pkg::*;
(
  input  logic [1:0] c0,
  input  logic [1:0] c1,
  input  logic [1:0] c2,
  input  logic [1:0] mark,
  output logic       hit,
  output logic [1:0] pos
);

  logic [1:0] nmark;
  logic [1:0] nempty;

  always_comb begin
    nmark  = {1'b0, c0 == mark} + {1'b0, c1 == mark} + {1'b0, c2 == mark};
    nempty = {1'b0, c0 == EMPTY} + {1'b0, c1 == EMPTY} + {1'b0, c2 == EMPTY};
    hit    = (nmark == 2'd2) && (nempty == 2'd1);
    pos    = 2'd0;
    if (c2 == EMPTY) pos = 2'd2;
    if (c1 == EMPTY) pos = 2'd1;
    if (c0 == EMPTY) pos = 2'd0;
  end

endmodule

// File: rtl/auto_player.sv
// Automated tic-tac-toe opponent: scans for win, then block, then preference order,
// strobes one move and waits for the board to show it, re-scanning on timeout.
module auto_player
  import ttt_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 15
) (
  input logic            ph1,
  input logic            reset,
  auto_player_if.master  bus
);

  localparam int unsigned TW = $clog2(RESP_TIMEOUT + 1);

  state_e      state_q, state_d;
  logic [2:0]  lcnt_q, lcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [17:0] board_q, board_d;
  logic [1:0]  own_q, own_d, opp_q, opp_d;
  cell_t       cell_q, cell_d;
  logic        pw_q, busy_q, nomove_q, nomove_d;
  cell_t       pin_q;

  logic        hit;
  logic [1:0]  pos;
  logic [1:0]  mark;
  cell_t       hit_cell, pick_cell;
  logic        pick_ok;
  logic [1:0]  live;

  assign mark = (state_q == StScanBlock) ? opp_q : own_q;
  assign live = cell_at(bus.gBoard, cell_q);

  line_eval u_line_eval (
    .c0   (cell_at(board_q, LINE_TBL[lcnt_q][0])),
    .c1   (cell_at(board_q, LINE_TBL[lcnt_q][1])),
    .c2   (cell_at(board_q, LINE_TBL[lcnt_q][2])),
    .mark (mark),
    .hit  (hit),
    .pos  (pos)
  );

  always_comb begin
    unique case (pos)
      2'd1:    hit_cell = LINE_TBL[lcnt_q][1];
      2'd2:    hit_cell = LINE_TBL[lcnt_q][2];
      default: hit_cell = LINE_TBL[lcnt_q][0];
    endcase
    // Walk backwards so the highest-preference empty cell wins.
    pick_ok   = 1'b0;
    pick_cell = '0;
    for (int k = 8; k >= 0; k--) begin
      if (cell_at(board_q, PICK_ORDER[k]) == EMPTY) begin
        pick_ok   = 1'b1;
        pick_cell = PICK_ORDER[k];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    lcnt_d   = lcnt_q;
    tcnt_d   = tcnt_q;
    board_d  = board_q;
    own_d    = own_q;
    opp_d    = opp_q;
    cell_d   = cell_q;
    nomove_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.myTurn && !bus.gameIsDone) begin
          board_d = bus.gBoard;
          own_d   = bus.isPlayer1 ? P1 : P2;
          opp_d   = bus.isPlayer1 ? P2 : P1;
          lcnt_d  = '0;
          state_d = StScanWin;
        end
      end
      StScanWin, StScanBlock: begin
        if (hit) begin
          cell_d  = hit_cell;
          state_d = StIssue;
        end else if (lcnt_q == 3'd7) begin
          lcnt_d  = '0;
          state_d = (state_q == StScanWin) ? StScanBlock : StPick;
        end else begin
          lcnt_d = lcnt_q + 3'd1;
        end
      end
      StPick: begin
        if (pick_ok) begin
          cell_d  = pick_cell;
          state_d = StIssue;
        end else begin
          nomove_d = 1'b1;
          state_d  = StIdle;
        end
      end
      StIssue: begin
        tcnt_d  = '0;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (live == own_q) begin
          state_d = StIdle;
        end else if (live != EMPTY || tcnt_q == TW'(RESP_TIMEOUT - 1)) begin
          board_d = bus.gBoard;
          lcnt_d  = '0;
          state_d = StScanWin;
        end else if (tcnt_q != '1) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (bus.gameIsDone) begin
      state_d  = StIdle;
      lcnt_d   = '0;
      tcnt_d   = '0;
      cell_d   = '0;
      nomove_d = 1'b0;
    end
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      lcnt_q   <= '0;
      tcnt_q   <= '0;
      board_q  <= '0;
      own_q    <= EMPTY;
      opp_q    <= EMPTY;
      cell_q   <= '0;
      pw_q     <= 1'b0;
      pin_q    <= '0;
      busy_q   <= 1'b0;
      nomove_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lcnt_q   <= lcnt_d;
      tcnt_q   <= tcnt_d;
      board_q  <= board_d;
      own_q    <= own_d;
      opp_q    <= opp_d;
      cell_q   <= cell_d;
      pw_q     <= (state_d == StIssue);
      pin_q    <= (state_d == StIssue) ? cell_d : '0;
      busy_q   <= (state_d != StIdle);
      nomove_q <= nomove_d;
    end
  end

  assign bus.playerWrite = pw_q;
  assign bus.playerInput = pin_q;
  assign bus.busy        = busy_q;
  assign bus.noMove      = nomove_q;

endmodule

// File: tb/tb_auto_player.sv
// Directed bench for auto_player: strobe timing, chosen cell, timeout, abort and reset.
module tb_auto_player;
  import ttt_pkg::*;

  logic ph1;
  logic reset;
  int   n_tests;
  int   n_fail;

  auto_player_if bus ();

  auto_player #(.RESP_TIMEOUT(15)) dut (
    .ph1   (ph1),
    .reset (reset),
    .bus   (bus)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  function automatic logic [17:0] put(input logic [17:0] b, input int idx,
                                      input logic [1:0] m);
    logic [17:0] r;
    r = b;
    r[2*idx +: 2] = m;
    return r;
  endfunction

  // Edge 0 is the edge on which IDLE sees myTurn; myTurn drops right after.
  task automatic start(input logic [17:0] b, input logic p1);
    bus.gBoard    = b;
    bus.isPlayer1 = p1;
    bus.myTurn    = 1'b1;
    tick();
    bus.myTurn    = 1'b0;
  endtask

  // Samples after edges 1..n; edges are reported where the output was first seen high.
  task automatic observe(input int n, output int first_e, output int second_e,
                         output int pin, output int npw, output int nm_e, output int nnm);
    first_e = -1; second_e = -1; pin = -1; npw = 0; nm_e = -1; nnm = 0;
    for (int e = 1; e <= n; e++) begin
      tick();
      if (bus.playerWrite) begin
        npw++;
        if (first_e < 0) begin
          first_e = e;
          pin     = int'(bus.playerInput);
        end else if (second_e < 0) begin
          second_e = e;
        end
      end
      if (bus.noMove) begin
        nnm++;
        if (nm_e < 0) nm_e = e;
      end
    end
  endtask

  task automatic abort();
    bus.gameIsDone = 1'b1;
    tick();
    check("abort_busy", int'(bus.busy), 0);
    bus.gameIsDone = 1'b0;
  endtask

  int f, s, p, n, m, nn;
  logic [17:0] b;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    bus.gBoard = '0; bus.myTurn = 1'b0; bus.isPlayer1 = 1'b1; bus.gameIsDone = 1'b0;
    tick(); tick();
    check("rst_pw", int'(bus.playerWrite), 0);
    check("rst_pin", int'(bus.playerInput), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_nomove", int'(bus.noMove), 0);
    reset = 1'b1;
    tick();

    // Empty board: centre via PICK, then ack with own mark.
    start('0, 1'b1);
    check("empty_busy", int'(bus.busy), 1);
    observe(20, f, s, p, n, m, nn);
    check("empty_pw_edge", f, 17);
    check("empty_pin", p, 4);
    check("empty_npw", n, 1);
    bus.gBoard = put('0, 4, P1);
    tick();
    check("empty_ack_busy", int'(bus.busy), 0);

    // Win on line 0, never acked: re-issue 17 cycles later with the same cell.
    b = put(put(put(put('0, 0, P1), 1, P1), 3, P2), 4, P2);
    start(b, 1'b1);
    observe(25, f, s, p, n, m, nn);
    check("win_pw_edge", f, 1);
    check("win_pin", p, 2);
    check("win_retry_edge", s, 18);
    check("win_npw", n, 2);
    abort();

    // Own 10 at 0, opponent 11 at 3,4: block on line 1.
    b = put(put(put('0, 0, P2), 3, P1), 4, P1);
    start(b, 1'b0);
    observe(12, f, s, p, n, m, nn);
    check("block_pw_edge", f, 10);
    check("block_pin", p, 5);
    abort();

    // Opponent on the centre only: first corner.
    start(put('0, 4, P2), 1'b1);
    observe(20, f, s, p, n, m, nn);
    check("pick_pw_edge", f, 17);
    check("pick_pin", p, 0);
    abort();

    // Full board: noMove pulse, no strobe.
    b = {2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11};
    start(b, 1'b1);
    observe(20, f, s, p, n, m, nn);
    check("full_npw", n, 0);
    check("full_nomove_edge", m, 17);
    check("full_nomove_cnt", nn, 1);
    check("full_busy", int'(bus.busy), 0);

    // gameIsDone raised after edge 5: idle after edge 6, no strobe.
    start('0, 1'b1);
    observe(5, f, s, p, n, m, nn);
    check("done_busy_pre", int'(bus.busy), 1);
    bus.gameIsDone = 1'b1;
    tick();
    check("done_busy_post", int'(bus.busy), 0);
    bus.gameIsDone = 1'b0;
    observe(20, f, s, p, n, m, nn);
    check("done_npw", n, 0);

    // Async reset while waiting for ack.
    b = put(put('0, 0, P1), 1, P1);
    start(b, 1'b1);
    observe(3, f, s, p, n, m, nn);
    check("rst2_pre_busy", int'(bus.busy), 1);
    #2 reset = 1'b0;
    #1;
    check("rst2_busy", int'(bus.busy), 0);
    check("rst2_pw", int'(bus.playerWrite), 0);
    check("rst2_pin", int'(bus.playerInput), 0);
    tick();
    reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
